seg_scan: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 13 +
 rtl/seg_scan_div.sv | 30 +++
 rtl/seg_scan.sv | 129 ++++++++++++
 tb/tb_seg_scan.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 8-digit 7-segment scan controller.
// BLANK code, default timing and code/buffer types.
package seg_scan_pkg;

   localparam logic [4:0]  INBLANK        = 5'h1F;
   localparam int unsigned DefDigitCycles = 100000;
   localparam int unsigned DefBlinkFrames = 64;
   localparam int unsigned NumDigits      = 8;

   typedef logic [4:0]                  code_t;
   typedef logic [NumDigits-1:0][4:0]   frame_t;

endpackage

// File: rtl/seg_scan_div.sv
// Digit slot counter: counts 0..DIGIT_CYCLES-1 and flags the terminal count.
module seg_scan_div
   import seg_scan_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES = DefDigitCycles
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int unsigned W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

   logic [W-1:0] div_q, div_d;

   assign tick_o = (div_q == W'(DIGIT_CYCLES - 1));

   always_comb begin
      div_d = tick_o ? '0 : div_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit scan controller with frame-aligned double buffering.
// Optional digit blinking is compiled in with `define SEG_BLINK_EN.
module seg_scan
   import seg_scan_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES = DefDigitCycles,
   parameter int unsigned BLINK_FRAMES = DefBlinkFrames
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic [39:0] codes_in_i,
   input  logic [7:0]  blink_mask_i,
   output logic [4:0]  seg_code_o,
   output logic [7:0]  seg_en_o,
   output logic        frame_tick_o,
   output logic        pending_o
);

   logic   tick;
   logic   boundary;
   logic   blank_d;
   logic   [2:0] idx_q, idx_d;
   frame_t active_q, active_d;
   frame_t pend_q, pend_d;
   logic   pending_q, pending_d;
   code_t  seg_code_q, seg_code_d;
   logic   [7:0] seg_en_q, seg_en_d;
   logic   frame_tick_q;

   seg_scan_div #(
      .DIGIT_CYCLES (DIGIT_CYCLES)
   ) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_o (tick)
   );

   assign boundary = tick && (idx_q == 3'd7);

   // A load in the boundary cycle bypasses the pending buffer entirely.
   always_comb begin
      idx_d     = idx_q;
      active_d  = active_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      if (tick) begin
         idx_d = idx_q + 3'd1;
      end
      if (boundary) begin
         if (load_i) begin
            active_d = frame_t'(codes_in_i);
         end else if (pending_q) begin
            active_d = pend_q;
         end
         pending_d = 1'b0;
      end else if (load_i) begin
         pend_d    = frame_t'(codes_in_i);
         pending_d = 1'b1;
      end
   end

`ifdef SEG_BLINK_EN
   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          phase_q, phase_d;

   always_comb begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (boundary) begin
         if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
            fcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
      blank_d = phase_d && blink_mask_i[idx_d];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{blink_mask_i, BLINK_FRAMES};
   assign blank_d    = 1'b0;
`endif

   // Outputs are computed from next state so digit enable and code move together.
   always_comb begin
      seg_code_d = blank_d ? INBLANK : active_d[idx_d];
      seg_en_d   = 8'd1 << idx_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         active_q     <= {NumDigits{INBLANK}};
         pend_q       <= {NumDigits{INBLANK}};
         pending_q    <= 1'b0;
         seg_code_q   <= INBLANK;
         seg_en_q     <= 8'h01;
         frame_tick_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pending_q    <= pending_d;
         seg_code_q   <= seg_code_d;
         seg_en_q     <= seg_en_d;
         frame_tick_q <= boundary;
      end
   end

   assign seg_code_o   = seg_code_q;
   assign seg_en_o     = seg_en_q;
   assign frame_tick_o = frame_tick_q;
   assign pending_o    = pending_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DIGIT_CYCLES=4, BLINK_FRAMES=2 (blink compiled out).
module tb_seg_scan;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [39:0] codes_in;
   logic [7:0]  blink_mask;
   logic [4:0]  seg_code;
   logic [7:0]  seg_en;
   logic        frame_tick;
   logic        pending;

   int checks   = 0;
   int failures = 0;
   int n        = 0;

   seg_scan #(
      .DIGIT_CYCLES (4),
      .BLINK_FRAMES (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load),
      .codes_in_i   (codes_in),
      .blink_mask_i (blink_mask),
      .seg_code_o   (seg_code),
      .seg_en_o     (seg_en),
      .frame_tick_o (frame_tick),
      .pending_o    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   function automatic logic [7:0] exp_en();
      return 8'd1 << ((n / 4) % 8);
   endfunction

   function automatic logic [7:0] exp_idx();
      return 8'((n / 4) % 8);
   endfunction

   function automatic logic [7:0] exp_tick();
      return {7'd0, (n > 0) && (n % 32 == 0)};
   endfunction

   initial begin
      rst_n      = 1'b0;
      load       = 1'b0;
      codes_in   = '0;
      blink_mask = 8'h00;
      repeat (2) @(negedge clk);

      check("rst_en",   seg_en, 8'h01);
      check("rst_code", {3'd0, seg_code}, 8'h1F);
      check("rst_pend", {7'd0, pending}, 8'h00);
      check("rst_tick", {7'd0, frame_tick}, 8'h00);

      rst_n = 1'b1;
      n     = 0;

      // Blank scan, no load
      while (n < 40) begin
         step();
         check("idle_en",   seg_en, exp_en());
         check("idle_code", {3'd0, seg_code}, 8'h1F);
         check("idle_tick", {7'd0, frame_tick}, exp_tick());
         check("idle_pend", {7'd0, pending}, 8'h00);
      end

      // Mid-frame load of codes 0..7
      codes_in = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
      load     = 1'b1;
      step();
      load     = 1'b0;
      check("ldA_pend", {7'd0, pending}, 8'h01);
      check("ldA_hold", {3'd0, seg_code}, 8'h1F);
      while (n < 63) begin
         step();
         check("ldA_pend", {7'd0, pending}, 8'h01);
         check("ldA_hold", {3'd0, seg_code}, 8'h1F);
         check("ldA_en",   seg_en, exp_en());
      end
      while (n < 96) begin
         step();
         check("ldA_code", {3'd0, seg_code}, exp_idx());
         check("ldA_en",   seg_en, exp_en());
         check("ldA_pend", {7'd0, pending}, 8'h00);
         check("ldA_tick", {7'd0, frame_tick}, exp_tick());
      end

      // Two loads in one frame: last wins
      while (n < 100) step();
      codes_in = {8{5'h01}};
      load     = 1'b1;
      step();
      load     = 1'b0;
      while (n < 110) begin
         step();
         check("ld2_old", {3'd0, seg_code}, exp_idx());
      end
      codes_in = {8{5'h02}};
      load     = 1'b1;
      step();
      load     = 1'b0;
      while (n < 127) begin
         step();
         check("ld2_old",  {3'd0, seg_code}, exp_idx());
         check("ld2_pend", {7'd0, pending}, 8'h01);
      end
      while (n < 159) begin
         step();
         check("ld2_code", {3'd0, seg_code}, 8'h02);
         check("ld2_en",   seg_en, exp_en());
         check("ld2_pend", {7'd0, pending}, 8'h00);
      end

      // Load in the boundary cycle goes straight to the active buffer
      codes_in = {5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8};
      load     = 1'b1;
      step();
      load     = 1'b0;
      check("bnd_pend", {7'd0, pending}, 8'h00);
      check("bnd_tick", {7'd0, frame_tick}, 8'h01);
      check("bnd_code", {3'd0, seg_code}, 8'h08);
      while (n < 191) begin
         step();
         check("bnd_code", {3'd0, seg_code}, exp_idx() + 8'd8);
         check("bnd_pend", {7'd0, pending}, 8'h00);
      end

      // Asynchronous reset mid-slot on digit 5 with a load pending
      while (n < 213) step();
      codes_in = {8{5'h03}};
      load     = 1'b1;
      step();
      load     = 1'b0;
      check("arst_pre_pend", {7'd0, pending}, 8'h01);
      check("arst_pre_en",   seg_en, 8'h20);
      #1 rst_n = 1'b0;
      #1;
      check("arst_en",   seg_en, 8'h01);
      check("arst_code", {3'd0, seg_code}, 8'h1F);
      check("arst_pend", {7'd0, pending}, 8'h00);
      check("arst_tick", {7'd0, frame_tick}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      n     = 0;
      while (n < 8) begin
         step();
         check("post_en",   seg_en, exp_en());
         check("post_code", {3'd0, seg_code}, 8'h1F);
         check("post_pend", {7'd0, pending}, 8'h00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
